// File: rtl/mips_shift_unit.sv
// Multi-cycle MIPS shifter: moves at most STEP bit positions per enabled cycle.
// Define SHIFT_ROTATE_EN to make op=11 a rotate right (ROTR/ROTRV); otherwise op=11 acts as SRL.
module mips_shift_unit #(
   parameter int WIDTH   = 32,
   parameter int STEP    = 4,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clk_enable,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   operand,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROT = 2'b11;

   localparam logic [SHAMT_W:0] STEP_L  = STEP[SHAMT_W:0];
   localparam logic [SHAMT_W:0] WIDTH_L = WIDTH[SHAMT_W:0];

   state_t               state, state_nx;
   logic [WIDTH-1:0]     work, work_nx;
   logic [SHAMT_W-1:0]   rem, rem_nx;
   logic [1:0]           op_r, op_nx;
   logic                 sign_r, sign_nx;
   logic [WIDTH-1:0]     result_nx;
   logic [SHAMT_W-1:0]   k;
   logic [WIDTH-1:0]     stepped;

   // One partial shift by k positions; SRA fill comes from the captured sign, not the live MSB.
   function automatic logic [WIDTH-1:0] shift_step(
      input logic [WIDTH-1:0]   v,
      input logic [SHAMT_W-1:0] amt,
      input logic [1:0]         o,
      input logic               s
   );
      logic [WIDTH-1:0] ones;
      logic signed [WIDTH-1:0] fill;
      ones = '1;
      fill = s ? $signed(~(ones >> amt)) : '0;
      case (o)
         OP_SLL: shift_step = v << amt;
         OP_SRL: shift_step = v >> amt;
         OP_SRA: shift_step = (v >> amt) | $unsigned(fill);
`ifdef SHIFT_ROTATE_EN
         OP_ROT: shift_step = (v >> amt) | (v << (WIDTH_L - {1'b0, amt}));
`else
         OP_ROT: shift_step = v >> amt;
`endif
         default: shift_step = v >> amt;
      endcase
   endfunction

   assign k       = ({1'b0, rem} > STEP_L) ? STEP_L[SHAMT_W-1:0] : rem;
   assign stepped = shift_step(work, k, op_r, sign_r);

   always_comb begin
      state_nx  = state;
      work_nx   = work;
      rem_nx    = rem;
      op_nx     = op_r;
      sign_nx   = sign_r;
      result_nx = result;
      case (state)
         IDLE: begin
            if (start) begin
               work_nx = operand;
               rem_nx  = shamt;
               op_nx   = op;
               sign_nx = operand[WIDTH-1];
               if (shamt == '0) begin
                  state_nx  = DONE;
                  result_nx = operand;
               end else begin
                  state_nx = SHIFT;
               end
            end
         end
         SHIFT: begin
            work_nx = stepped;
            rem_nx  = rem - k;
            if (rem == k) begin
               state_nx  = DONE;
               result_nx = stepped;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and working registers; a stalled clk_enable freezes everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         work   <= '0;
         rem    <= '0;
         op_r   <= '0;
         sign_r <= 1'b0;
         result <= '0;
      end else if (clk_enable) begin
         state  <= state_nx;
         work   <= work_nx;
         rem    <= rem_nx;
         op_r   <= op_nx;
         sign_r <= sign_nx;
         result <= result_nx;
      end
   end

   assign busy = (state == SHIFT) || (state == DONE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_mips_shift_unit.sv
// Bench for mips_shift_unit: cycle-level reference model plus directed literal vectors.
module tb_mips_shift_unit;

   localparam int WIDTH   = 32;
   localparam int STEP    = 4;
   localparam int SHAMT_W = 5;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               clk_enable = 1'b1;
   logic               start = 1'b0;
   logic [1:0]         op = 2'b00;
   logic [SHAMT_W-1:0] shamt = '0;
   logic [WIDTH-1:0]   operand = '0;
   logic               busy, done;
   logic [WIDTH-1:0]   result;

   int checks = 0;
   int errors = 0;

   mips_shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
      .op(op), .shamt(shamt), .operand(operand),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input int sh, input logic [31:0] v);
      case (o)
         2'b00: ref_shift = v << sh;
         2'b01: ref_shift = v >> sh;
         2'b10: ref_shift = $unsigned($signed(v) >>> sh);
`ifdef SHIFT_ROTATE_EN
         default: ref_shift = (v >> sh) | (v << (32 - sh));
`else
         default: ref_shift = v >> sh;
`endif
      endcase
   endfunction

   // Model: an accepted request stays busy for ceil(shamt/STEP) enabled cycles, then one done cycle.
   bit          model_on = 1'b0;
   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [31:0] m_result = '0, m_pending = '0;
   int          m_cnt = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_result = '0; m_cnt = 0;
      end else if (clk_enable) begin
         if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
         end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin m_done = 1'b1; m_result = m_pending; end
         end else if (start) begin
            m_pending = ref_shift(op, int'(shamt), operand);
            m_cnt     = (int'(shamt) + STEP - 1) / STEP;
            m_busy    = 1'b1;
            if (m_cnt == 0) begin m_done = 1'b1; m_result = m_pending; end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         checks++;
         if (busy !== m_busy || done !== m_done || result !== m_result) begin
            errors++;
            $display("FAIL model t=%0t: busy=%b done=%b result=%h, required busy=%b done=%b result=%h",
                     $time, busy, done, result, m_busy, m_done, m_result);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Issue one request and wait (bounded) for done; n counts negedges after the accepting edge.
   task automatic run_op(input string name, input logic [1:0] o, input int sh, input logic [31:0] v,
                         input logic [31:0] exp_r, input int exp_n, input int exp_busy,
                         input bit poke, input bit stall);
      int n, busy_n;
      @(negedge clk);
      op = o; shamt = sh[SHAMT_W-1:0]; operand = v; start = 1'b1;
      @(negedge clk);
      start = 1'b0; operand = ~v; op = ~o; shamt = ~shamt;
      n = 1; busy_n = 0;
      forever begin
         if (busy) busy_n++;
         if (done) break;
         if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles, required %0d", name, n, exp_n);
            break;
         end
         if (poke && n == 2) begin start = 1'b1; operand = 32'hDEAD_BEEF; shamt = 5'd1; end
         if (poke && n == 3) start = 1'b0;
         if (stall && n == 1) clk_enable = 1'b0;
         if (stall && n == 4) clk_enable = 1'b1;
         @(negedge clk);
         n++;
      end
      check({name, "_result"}, result, exp_r);
      check({name, "_latency"}, n, exp_n);
      if (exp_busy > 0) check({name, "_busy_cycles"}, busy_n, exp_busy);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_on = 1'b1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);

      run_op("srl_sh0", 2'b01, 0, 32'h0000_6006, 32'h0000_6006, 1, 1, 0, 0);
      run_op("sra_sh31", 2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, 9, 9, 0, 0);
      run_op("sll_sh31", 2'b00, 31, 32'h0000_0001, 32'h8000_0000, 9, 9, 0, 0);
`ifdef SHIFT_ROTATE_EN
      run_op("rot_sh1", 2'b11, 1, 32'h0000_0001, 32'h8000_0000, 2, 0, 0, 0);
`else
      run_op("rot_sh1", 2'b11, 1, 32'h0000_0001, 32'h0000_0000, 2, 0, 0, 0);
`endif
      run_op("sll_sh8", 2'b00, 8, 32'h1234_5678, 32'h3456_7800, 3, 0, 0, 0);
      run_op("sra_pos5", 2'b10, 5, 32'h7FFF_0000, 32'h03FF_F800, 3, 0, 0, 0);
      run_op("sra_neg3", 2'b10, 3, 32'hF000_0000, 32'hFE00_0000, 2, 0, 0, 0);
      run_op("srl_sh7", 2'b01, 7, 32'h8000_0001, 32'h0100_0000, 3, 0, 0, 0);
      run_op("srl_poke", 2'b01, 16, 32'hFFFF_0000, 32'h0000_FFFF, 5, 5, 1, 0);
      run_op("srl_stall", 2'b01, 12, 32'hF000_0000, 32'h000F_0000, 7, 0, 0, 1);

      // done must hold while clk_enable is low in DONE
      @(negedge clk);
      op = 2'b00; shamt = 5'd4; operand = 32'h0000_0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("hold_done_entry", done, 1);
      check("hold_result", result, 32'h0000_0010);
      clk_enable = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("hold_done_stalled", done, 1);
      end
      clk_enable = 1'b1;
      @(negedge clk);
      check("hold_done_release", done, 0);

      // reset in the middle of a shift abandons it
      @(negedge clk);
      op = 2'b00; shamt = 5'd31; operand = 32'h0000_0003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      check("midreset_result", result, 0);
      begin
         int seen;
         seen = 0;
         repeat (12) begin
            @(negedge clk);
            if (done) seen++;
         end
         check("midreset_no_done", seen, 0);
      end
      run_op("after_reset", 2'b01, 4, 32'h0000_00F0, 32'h0000_000F, 2, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

endmodule
